// File: rtl/mio_bus_ws.sv
// mio_bus_ws: memory-mapped I/O bus controller with wait states.
// Decodes a CPU request onto one of N_SLOTS peripheral slots by the top
// DEC_W address bits. The transaction completes on that slot's ack. An
// unmapped address or a slot that never acks produces an error response
// instead of stalling the CPU forever.
//
// Ports:
//   clk, RSTN       bus clock, asynchronous active-low reset
//   req/we/addr/wdata   CPU request, held stable until ready
//   rdata/ready/err     one-cycle completion pulse with read data and error flag
//   busy                controller is not idle
//   err_cnt             saturating count of error responses
//   slot_sel            one-hot slot select, asserted only during ACCESS
//   slot_we/addr/wdata  registered request towards the slots
//   slot_rdata/slot_ack packed per-slot read data and completion strobes
module mio_bus_ws #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned DEC_W   = 4,
    parameter logic [DEC_W*N_SLOTS-1:0] SLOT_BASES = {4'hF, 4'hE, 4'h1, 4'h0},
    parameter int unsigned TIMEOUT = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      RSTN,
    input  logic                      req,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ready,
    output logic                      err,
    output logic                      busy,
    output logic [7:0]                err_cnt,
    output logic [N_SLOTS-1:0]        slot_sel,
    output logic                      slot_we,
    output logic [ADDR_W-1:0]         slot_addr,
    output logic [DATA_W-1:0]         slot_wdata,
    input  logic [N_SLOTS*DATA_W-1:0] slot_rdata,
    input  logic [N_SLOTS-1:0]        slot_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state, state_nx;
    logic [N_SLOTS-1:0]   sel_q;
    logic [N_SLOTS-1:0]   dec_sel;
    logic                 dec_hit;
    logic [DEC_W-1:0]     dec_field;
    logic [7:0]           cnt;
    logic                 ack_hit;
    logic [DATA_W-1:0]    ack_data;

    // Address-window decode; the first matching slot (lowest index) wins.
    always_comb begin
        dec_field = addr[ADDR_W-1 -: DEC_W];
        dec_sel   = '0;
        dec_hit   = 1'b0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (!dec_hit && dec_field == SLOT_BASES[i*DEC_W +: DEC_W]) begin
                dec_sel[i] = 1'b1;
                dec_hit    = 1'b1;
            end
        end
    end

    // Only the selected slot's ack and data matter; stray acks are masked.
    always_comb begin
        ack_hit  = |(slot_ack & sel_q);
        ack_data = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (sel_q[i]) begin
                ack_data = slot_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = dec_hit ? ACCESS : RESP;
            ACCESS:  if (ack_hit || cnt == 8'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            rdata      <= '0;
            err        <= 1'b0;
            err_cnt    <= '0;
            sel_q      <= '0;
            cnt        <= '0;
            slot_we    <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        slot_addr  <= addr;
                        slot_we    <= we;
                        slot_wdata <= wdata;
                        sel_q      <= dec_sel;
                        cnt        <= 8'(TIMEOUT);
                        if (!dec_hit) begin
                            err   <= 1'b1;
                            rdata <= ERR_DATA;
                        end
                    end
                end
                ACCESS: begin
                    // An ack on the final counted cycle still beats the timeout.
                    if (ack_hit) begin
                        rdata <= ack_data;
                        err   <= 1'b0;
                    end else if (cnt == 8'd0) begin
                        err   <= 1'b1;
                        rdata <= ERR_DATA;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (err && err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready    = (state == RESP);
    assign busy     = (state != IDLE);
    assign slot_sel = (state == ACCESS) ? sel_q : '0;

endmodule

// File: tb/tb_mio_bus_ws.sv
// Directed bench for mio_bus_ws: each transaction pushes its expected
// response to a scoreboard queue, which is popped when ready appears.
// Bases are overridden so slot 1 sits at 0xE..., slot 2 at 0xF..., slot 3 at 0x1...
module tb_mio_bus_ws;

    logic         clk;
    logic         RSTN;
    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         ready;
    logic         err;
    logic         busy;
    logic [7:0]   err_cnt;
    logic [3:0]   slot_sel;
    logic         slot_we;
    logic [31:0]  slot_addr;
    logic [31:0]  slot_wdata;
    logic [127:0] slot_rdata;
    logic [3:0]   slot_ack;

    int checks;
    int errors;
    logic [32:0] sb[$];

    mio_bus_ws #(
        .ADDR_W(32), .DATA_W(32), .N_SLOTS(4), .DEC_W(4),
        .SLOT_BASES({4'h1, 4'hF, 4'hE, 4'h0}),
        .TIMEOUT(15), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .RSTN(RSTN), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .busy(busy), .err_cnt(err_cnt),
        .slot_sel(slot_sel), .slot_we(slot_we), .slot_addr(slot_addr),
        .slot_wdata(slot_wdata), .slot_rdata(slot_rdata), .slot_ack(slot_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ack_at: ACCESS cycle index (0-based) on which the selected slot acks, -1 = never.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] exp_sel, input int ack_at, input logic [31:0] rd_val,
                       input logic stray, input logic exp_err, input int exp_lat, input int exp_acc);
        int lat;
        int acc;
        logic sel_bad;
        logic done;
        logic [32:0] e;
        sb.push_back({exp_err, exp_err ? 32'hDEAD_BEEF : rd_val});
        for (int i = 0; i < 4; i++) slot_rdata[i*32 +: 32] = exp_sel[i] ? rd_val : ~rd_val;
        req = 1'b1; we = w; addr = a; wdata = wd;
        lat = 0; acc = 0; sel_bad = 1'b0; done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            slot_ack = '0;
            if (ready) begin
                done = 1'b1;
                req  = 1'b0;
                e = sb.pop_front();
                chk("rdata", rdata, e[31:0]);
                chk("err", 32'(err), 32'(e[32]));
            end else if (slot_sel != 4'b0000) begin
                if (slot_sel !== exp_sel || !busy) sel_bad = 1'b1;
                if (acc == ack_at) slot_ack = exp_sel;
                if (stray && acc < 2) slot_ack = slot_ack | 4'b1000;
                acc++;
            end
        end
        req = 1'b0;
        chk("completed", 32'(done), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("access_cycles", 32'(acc), 32'(exp_acc));
        chk("sel_onehot", 32'(sel_bad), 32'd0);
        chk("slot_we", 32'(slot_we), 32'(w));
        chk("slot_addr", slot_addr, a);
        chk("slot_wdata", slot_wdata, wd);
        @(negedge clk);
        chk("ready_pulse", 32'(ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0;
        RSTN = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        slot_rdata = '0; slot_ack = '0;
        #12;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_busy", 32'({ready, err, busy}), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("rst_slot", 32'({slot_sel, slot_we}), 32'h0);
        @(negedge clk); RSTN = 1'b1;
        @(negedge clk);

        // Read slot 0, ack on first ACCESS cycle.
        txn(1'b0, 32'h0000_0010, 32'h0, 4'b0001, 0, 32'h1234_5678, 1'b0, 1'b0, 2, 1);
        // Write slot 2, ack on the fourth ACCESS cycle.
        txn(1'b1, 32'hF000_0000, 32'hA5A5_0001, 4'b0100, 3, 32'h0BAD_F00D, 1'b0, 1'b0, 5, 4);
        chk("err_cnt_0", 32'(err_cnt), 32'd0);
        // Unmapped address.
        txn(1'b0, 32'h8000_0000, 32'h0, 4'b0000, -1, 32'h0, 1'b0, 1'b1, 1, 0);
        chk("err_cnt_1", 32'(err_cnt), 32'd1);
        // Slot 1 never acks: 16 ACCESS cycles then error.
        txn(1'b0, 32'hE000_0000, 32'h0, 4'b0010, -1, 32'h5555_AAAA, 1'b0, 1'b1, 17, 16);
        chk("err_cnt_2", 32'(err_cnt), 32'd2);
        // Ack on the last ACCESS cycle wins over timeout.
        txn(1'b0, 32'hE000_0004, 32'h0, 4'b0010, 15, 32'hCAFE_0001, 1'b0, 1'b0, 17, 16);
        chk("err_cnt_last_ack", 32'(err_cnt), 32'd2);
        // Stray ack from slot 3 during a slot 0 access is ignored.
        txn(1'b0, 32'h0000_0020, 32'h0, 4'b0001, 2, 32'h7777_1111, 1'b1, 1'b0, 4, 3);

        // Reset in the middle of an ACCESS to slot 1.
        for (int i = 0; i < 4; i++) slot_rdata[i*32 +: 32] = 32'h0;
        req = 1'b1; we = 1'b1; addr = 32'hE000_0008; wdata = 32'h1111_2222;
        repeat (3) @(negedge clk);
        chk("pre_rst_sel", 32'(slot_sel), 32'h2);
        #2 RSTN = 1'b0;
        #1;
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_flags", 32'({ready, err, busy}), 32'h0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("mid_rst_sel_we", 32'({slot_sel, slot_we}), 32'h0);
        chk("mid_rst_addr", slot_addr, 32'h0);
        chk("mid_rst_wdata", slot_wdata, 32'h0);
        req = 1'b0;
        @(negedge clk); RSTN = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_abandoned_ready", 32'(ready), 32'd0);
        end
        txn(1'b0, 32'h0000_0030, 32'h0, 4'b0001, 1, 32'h2468_ACE0, 1'b0, 1'b0, 3, 2);
        chk("err_cnt_after_rst", 32'(err_cnt), 32'd0);

        // Saturation of the error counter.
        for (int n = 0; n < 300; n++) begin
            txn(1'b0, 32'h8000_0000 | 32'(n), 32'h0, 4'b0000, -1, 32'h0, 1'b0, 1'b1, 1, 0);
            if (n == 254) chk("err_cnt_254", 32'(err_cnt), 32'd255);
        end
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mio_bus_ws.md
Name: mio_bus_ws

Overview:
Parametrised memory-mapped I/O bus controller with wait states, the successor to the fixed-decode CPU-to-peripheral bus. It sits between the single-cycle CPU data port and N peripheral slots (data RAM, GPIO, counter, display and similar). Each slot is selected by address-window decode and completes through a per-slot ack handshake, so slow peripherals can stall the CPU through `ready`. Unmapped addresses and hung peripherals return a bus error instead of hanging the CPU.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- N_SLOTS, 4, number of peripheral slots (1..8).
- DEC_W, 4, number of top address bits used for decode, taken as addr[ADDR_W-1 -: DEC_W].
- SLOT_BASES, {4'hF,4'hE,4'h1,4'h0}, packed DEC_W*N_SLOTS bits; slot i base value is bits [i*DEC_W +: DEC_W].
- TIMEOUT, 15, maximum ACCESS cycles waiting for ack (1..255).
- ERR_DATA, 32'hDEAD_BEEF, value driven on rdata for an error response.

Ports:
- clk  in  1  single bus clock.
- RSTN  in  1  reset, asynchronous, active-low.
- req  in  1  CPU request; held with addr/we/wdata stable until `ready`.
- we  in  1  1 = write, 0 = read.
- addr  in  ADDR_W  CPU byte address.
- wdata  in  DATA_W  CPU write data.
- rdata  out  DATA_W  read data, valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  qualifies ready; 1 = unmapped address or timeout.
- busy  out  1  high in any state other than IDLE.
- err_cnt  out  8  saturating bus-error count.
- slot_sel  out  N_SLOTS  one-hot slot select.
- slot_we  out  1  registered write enable to slots.
- slot_addr  out  ADDR_W  registered address.
- slot_wdata  out  DATA_W  registered write data.
- slot_rdata  in  N_SLOTS*DATA_W  packed slot read data; slot i uses [i*DATA_W +: DATA_W].
- slot_ack  in  N_SLOTS  per-slot completion.

Behaviour:
- Reset (RSTN=0, asynchronous) forces:
  - state to IDLE
  - rdata=0, ready=0, err=0, busy=0, err_cnt=0
  - slot_sel=0, slot_we=0, slot_addr=0, slot_wdata=0
- Reset asserted mid-transaction abandons the transaction. No ready is issued for it.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - When req=1, register addr/we/wdata into slot_addr/slot_we/slot_wdata.
  - Decode the slot. If several bases match, the lowest index wins.
  - Mapped address: load the timeout counter with TIMEOUT and go to ACCESS.
  - Unmapped address: go to RESP with err=1 and rdata=ERR_DATA.
- ACCESS:
  - slot_sel[k]=1 for the decoded slot k, held for every ACCESS cycle; all other bits are 0.
  - slot_ack[k]=1: capture slot_rdata[k] into rdata (for writes too), go to RESP with err=0.
  - Acks from non-selected slots are ignored.
  - Otherwise decrement the counter. If the counter is 0 and no ack is present, go to RESP with err=1 and rdata=ERR_DATA.
  - An ack arriving in the same cycle the counter reaches 0 wins: err=0.
- RESP:
  - ready=1 for exactly one cycle; slot_sel=0. Then go to IDLE.
  - The requester must drop req in the ready cycle. If req is still 1 in the following IDLE cycle, it starts a new transaction.
- Latency:
  - Mapped access with ack in the first ACCESS cycle: ready is high 2 cycles after req is sampled.
  - Each extra ack delay cycle adds 1 cycle.
  - Unmapped access: ready 1 cycle after sample.
  - Worst-case timeout: ready TIMEOUT+1 cycles after ACCESS entry.
- rdata, err and slot_* registers hold their last values outside RESP/ACCESS, except slot_sel.
- err_cnt increments on each ready with err=1 and saturates at 255.
- busy = (state != IDLE).

Test Plan:
- Read slot 0: addr=0x0000_0010, ack in the first ACCESS cycle, slot_rdata[0]=0x1234_5678 -> slot_sel=4'b0001 for 1 cycle; ready 2 cycles after req with rdata=0x1234_5678, err=0.
- Write slot 2: addr=0xF000_0000, wdata=0xA5A5_0001, ack delayed 3 cycles -> slot_we=1, slot_wdata=0xA5A5_0001, slot_sel=4'b0100 held 4 cycles; ready at cycle 5, err=0.
- Unmapped: addr=0x8000_0000 -> ready 1 cycle after req, err=1, rdata=0xDEAD_BEEF, slot_sel never asserted, err_cnt=1.
- Timeout: slot 1 (addr=0xE000_0000) never acks -> slot_sel[1] high for 16 cycles, then ready with err=1 and rdata=0xDEAD_BEEF; ack arriving on the last ACCESS cycle instead gives err=0.
- Stray ack: slot_ack[3]=1 while slot 0 is selected -> ignored, the transaction continues.
- Reset and saturation:
  - RSTN low during ACCESS -> all outputs 0 immediately; after release, a new read completes normally.
  - 300 error transactions -> err_cnt=255.
